// File: rtl/ppu_status_if.sv
// PPU status bus: sprite-unit flag levels plus the CPU register port
// ($2000-$2007 select, strobe, data) and the $2002 read results.
interface ppu_status_if;
  logic       sp_over_in;
  logic       sp0_hit_in;
  logic [2:0] ri_sel_in;
  logic       ri_ncs_in;
  logic       ri_r_nw_in;
  logic [7:0] ri_d_in;
  logic [7:0] status_dout;
  logic       toggle_clr_out;

  modport master (
    output sp_over_in, sp0_hit_in, ri_sel_in, ri_ncs_in, ri_r_nw_in, ri_d_in,
    input  status_dout, toggle_clr_out
  );

  modport slave (
    input  sp_over_in, sp0_hit_in, ri_sel_in, ri_ncs_in, ri_r_nw_in, ri_d_in,
    output status_dout, toggle_clr_out
  );
endinterface

// File: rtl/ppu_status.sv
// PPU dot/scanline timing and the PPUSTATUS ($2002) register: sticky sprite
// flags, the vblank flag with its read race, the scroll-toggle clear pulse
// and the active-low vblank NMI.
module ppu_status #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBL_LINE        = 241,
  parameter int PRE_LINE        = 261
) (
  input  logic              clk_in,
  input  logic              rst_in,
  ppu_status_if.slave       bus,
  output logic              nvbl_out,
  output logic              vblank_out,
  output logic [8:0]        dot_out,
  output logic [8:0]        scanline_out
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_L     = 9'(VBL_LINE);
  localparam logic [8:0] PRE_L     = 9'(PRE_LINE);

  logic [8:0] dot_q, dot_d;
  logic [8:0] scanline_q, scanline_d;
  logic       odd_frame_q, odd_frame_d;
  logic       vblank_q, vblank_d;
  logic       sp0_q, sp0_d;
  logic       over_q, over_d;
  logic       nmi_en_q, nmi_en_d;
  logic       render_en_q, render_en_d;
  logic [4:0] open_bus_q, open_bus_d;
  logic [7:0] status_q, status_d;
  logic       toggle_clr_q, toggle_clr_d;
  logic       nvbl_q, nvbl_d;
  logic       ncs_prev_q, ncs_prev_d;

  logic strobe;
  logic wr_strobe;
  logic rd_status;
  logic vbl_set_cycle;
  logic pre_clr_cycle;
  logic vblank_eff;

  // Next-state logic: frame timing, register writes, $2002 read effects.
  always_comb begin
    dot_d        = dot_q;
    scanline_d   = scanline_q;
    odd_frame_d  = odd_frame_q;
    vblank_d     = vblank_q;
    sp0_d        = sp0_q;
    over_d       = over_q;
    nmi_en_d     = nmi_en_q;
    render_en_d  = render_en_q;
    open_bus_d   = open_bus_q;
    status_d     = status_q;
    toggle_clr_d = 1'b0;
    ncs_prev_d   = bus.ri_ncs_in;

    strobe        = ~bus.ri_ncs_in & ncs_prev_q;
    wr_strobe     = strobe & ~bus.ri_r_nw_in;
    rd_status     = strobe & bus.ri_r_nw_in & (bus.ri_sel_in == 3'd2);
    vbl_set_cycle = (scanline_q == VBL_L) && (dot_q == 9'd1);
    pre_clr_cycle = (scanline_q == PRE_L) && (dot_q == 9'd1);
    // A read landing on the set cycle sees vblank low and also blocks the set.
    vblank_eff    = vbl_set_cycle ? 1'b0 : vblank_q;

    if ((scanline_q == LAST_LINE) && (dot_q == SKIP_DOT) && render_en_q && odd_frame_q) begin
      dot_d       = 9'd0;
      scanline_d  = 9'd0;
      odd_frame_d = ~odd_frame_q;
    end else if (dot_q == LAST_DOT) begin
      dot_d = 9'd0;
      if (scanline_q == LAST_LINE) begin
        scanline_d  = 9'd0;
        odd_frame_d = ~odd_frame_q;
      end else begin
        scanline_d = scanline_q + 9'd1;
      end
    end else begin
      dot_d = dot_q + 9'd1;
    end

    if (rd_status || pre_clr_cycle) begin
      vblank_d = 1'b0;
    end else if (vbl_set_cycle) begin
      vblank_d = 1'b1;
    end

    if (pre_clr_cycle) begin
      sp0_d  = 1'b0;
      over_d = 1'b0;
    end else begin
      if (bus.sp0_hit_in) sp0_d = 1'b1;
      if (bus.sp_over_in) over_d = 1'b1;
    end

    if (wr_strobe) begin
      open_bus_d = bus.ri_d_in[4:0];
      if (bus.ri_sel_in == 3'd0) nmi_en_d = bus.ri_d_in[7];
      if (bus.ri_sel_in == 3'd1) render_en_d = bus.ri_d_in[3] | bus.ri_d_in[4];
    end

    if (rd_status) begin
      status_d     = {vblank_eff, sp0_q, over_q, open_bus_q};
      toggle_clr_d = 1'b1;
    end

    nvbl_d = ~(vblank_q & nmi_en_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      dot_q        <= 9'd0;
      scanline_q   <= 9'd0;
      odd_frame_q  <= 1'b0;
      vblank_q     <= 1'b0;
      sp0_q        <= 1'b0;
      over_q       <= 1'b0;
      nmi_en_q     <= 1'b0;
      render_en_q  <= 1'b0;
      open_bus_q   <= 5'd0;
      status_q     <= 8'd0;
      toggle_clr_q <= 1'b0;
      nvbl_q       <= 1'b1;
      ncs_prev_q   <= 1'b1;
    end else begin
      dot_q        <= dot_d;
      scanline_q   <= scanline_d;
      odd_frame_q  <= odd_frame_d;
      vblank_q     <= vblank_d;
      sp0_q        <= sp0_d;
      over_q       <= over_d;
      nmi_en_q     <= nmi_en_d;
      render_en_q  <= render_en_d;
      open_bus_q   <= open_bus_d;
      status_q     <= status_d;
      toggle_clr_q <= toggle_clr_d;
      nvbl_q       <= nvbl_d;
      ncs_prev_q   <= ncs_prev_d;
    end
  end

  assign bus.status_dout    = status_q;
  assign bus.toggle_clr_out = toggle_clr_q;
  assign nvbl_out           = nvbl_q;
  assign vblank_out         = vblank_q;
  assign dot_out            = dot_q;
  assign scanline_out       = scanline_q;

endmodule

// File: doc/ppu_status.md
Name: ppu_status

Overview:
- Consumer end of the sprite-unit flag interface (sprite overflow and sprite-0 hit), plus the PPU dot/scanline timing it depends on.
- Holds the PPUSTATUS ($2002) register: sticky sprite flags, the vblank flag, and the CPU read-side effects.
- Generates the active-low vblank NMI.
- Sits between the sprite unit and the CPU register interface.

Parameters:
- DOTS_PER_LINE, 341, dots per scanline (dot counter 0..340).
- LINES_PER_FRAME, 262, scanlines per frame (0..261).
- VBL_LINE, 241, scanline on which vblank is set at dot 1.
- PRE_LINE, 261, pre-render scanline; flags are cleared at dot 1.

Ports:
- clk_in  input  1  PPU clock; one cycle = one dot.
- rst_in  input  1  reset.
- sp_over_in  input  1  sprite overflow level from the sprite unit.
- sp0_hit_in  input  1  sprite-0 hit level from the sprite unit.
- ri_sel_in  input  3  CPU register select.
- ri_ncs_in  input  1  CPU chip select, active low.
- ri_r_nw_in  input  1  1 = read, 0 = write.
- ri_d_in  input  8  CPU write data.
- status_dout  output  8  PPUSTATUS value captured on the last $2002 read.
- toggle_clr_out  output  1  one-cycle pulse on a $2002 read; clears the scroll/address write toggle.
- nvbl_out  output  1  NMI to the CPU, active low.
- vblank_out  output  1  current vblank flag.
- dot_out  output  9  current dot.
- scanline_out  output  9  current scanline.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While rst_in == 0, sampled at the clk_in edge:
  - dot = 0, scanline = 0, odd_frame = 0.
  - vblank, sp0, over, nmi_en, render_en = 0.
  - open-bus latch = 0, status_dout = 0, toggle_clr_out = 0, nvbl_out = 1.
  - Reset mid-frame restarts timing at (0,0) on the next cycle.
- Access strobe: registered ncs_prev. An access occurs only on the cycle where ri_ncs_in == 0 and ncs_prev == 1. Holding ncs low gives exactly one access.
- Writes (ri_r_nw_in == 0):
  - Any register: open-bus latch <= ri_d_in[4:0].
  - sel 0: nmi_en <= ri_d_in[7].
  - sel 1: render_en <= ri_d_in[3] | ri_d_in[4].
  - Writes to sel 2 have no other effect.
- Read of sel 2:
  - status_dout <= {vblank_eff, sp0, over, open-bus latch}, registered, valid the cycle after the strobe and held until the next $2002 read.
  - vblank is cleared on the following cycle.
  - toggle_clr_out = 1 for exactly one cycle, the cycle after the strobe.
  - Reads of other sel values do nothing.
- Timing counters:
  - dot increments every cycle. At dot 340 it wraps to 0 and scanline increments; scanline wraps 261 -> 0, toggling odd_frame.
  - Odd-frame skip: on scanline 261, dot 339, with render_en == 1 and odd_frame == 1, the next state is (0,0), skipping dot 340.
- Vblank:
  - Set on the cycle scanline == VBL_LINE and dot == 1.
  - Cleared at PRE_LINE dot 1, or by a $2002 read.
  - Race: a $2002 read strobe on the exact set cycle returns vblank_eff = 0 and suppresses the set for that frame, so no NMI that frame. Otherwise vblank_eff = vblank.
- Sprite flags:
  - sp0 is set on any cycle sp0_hit_in == 1; over is set on any cycle sp_over_in == 1. Both are sticky.
  - Both are cleared at PRE_LINE dot 1; the clear wins over a simultaneous set.
  - Reads do not clear them.
- NMI:
  - nvbl_out = ~(vblank & nmi_en), registered: one cycle after either term changes.
  - Writing nmi_en = 1 while vblank is set asserts NMI immediately. Writing 0 releases it.
- Outputs: dot_out, scanline_out and vblank_out are direct register values.

Test Plan:
- Reset, then 262*341 cycles with render_en = 0 -> vblank_out rises at (241,1) and falls at (261,1). The frame has 89342 cycles; the second frame is the same length.
- Write sel 1 with 0x18, run two frames -> the odd frame is 89341 cycles (dot 340 skipped on line 261); the even frame is 89342.
- Write sel 0 with 0x80, run to (241,1) -> nvbl_out goes 0 one cycle later. Read $2002 -> status_dout[7] = 1, toggle_clr_out pulses once, vblank clears, nvbl_out returns to 1.
- Read $2002 on the exact (241,1) cycle with nmi_en = 1 -> status_dout[7] = 0, vblank stays 0, nvbl_out stays 1 for the whole frame.
- Pulse sp0_hit_in on (30,100) and sp_over_in on (50,10), write 0x15 -> a read at line 200 returns 0x75 (vblank clear). Flags remain set after the read, and a read after (261,1) returns 0x15. With sp0_hit_in held high across (261,1), sp0 reads 0 at (261,2) and 1 at (261,3).
- Hold ri_ncs_in low for 10 cycles with sel 2, read -> exactly one toggle_clr_out pulse. Assert rst_in = 0 mid-vblank -> on the next cycle all outputs are at reset values and nvbl_out = 1.
